// File: rtl/vehicle_can_pkg.sv
// Shared definitions for the vehicle CAN receive path: default frame IDs,
// decoded value widths, receive FSM state constants, frame classes and the
// payload validity rules for engine-revolution and vehicle-speed frames.
package vehicle_can_pkg;

   // Default CAN identifiers of the two frames this receiver decodes.
   localparam logic [10:0] DEF_ID_ENGINE_REV = 11'h3D9;
   localparam logic [10:0] DEF_ID_CAR_SPEED  = 11'h3E9;

   // Widths of the decoded values (rpm and km/h).
   localparam int ENGINE_REV_W    = 14;
   localparam int VEHICLE_SPEED_W = 9;

   // Receive FSM state. Kept as plain constants over a 2-bit vector so the
   // encoding stays stable for code that compares against raw values.
   typedef logic [1:0] rx_state_t;
   localparam rx_state_t ST_IDLE   = 2'd0;
   localparam rx_state_t ST_DECODE = 2'd1;
   localparam rx_state_t ST_COMMIT = 2'd2;

   // Frame classification produced in DECODE.
   typedef enum logic [1:0] {
      FRM_OTHER  = 2'd0,
      FRM_ENGINE = 2'd1,
      FRM_SPEED  = 2'd2
   } frame_kind_t;

   // Engine frame: both low bytes present, top two bits of byte1 clear
   // (anything else would overflow the 14-bit rpm field).
   function automatic logic engine_frame_ok(input logic [1:0] keep,
                                            input logic [7:0] byte1);
      return (keep == 2'b11) && (byte1[7:6] == 2'b00);
   endfunction

   // Speed frame: both low bytes present, only bit 0 of byte1 may be set
   // (9-bit km/h field).
   function automatic logic speed_frame_ok(input logic [1:0] keep,
                                           input logic [7:0] byte1);
      return (keep == 2'b11) && (byte1[7:1] == 7'd0);
   endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Staleness timer: counts cycles since the last kick, saturating at
// TIMEOUT_CYCLE; stale is high while the count sits at saturation.
// Ports: clk, rst_n (sync, active-low; reset leaves the timer saturated so
// a value is stale until first written), kick (clear strobe), stale (output).
module rx_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLE = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   output logic stale
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLE < 1) ? 1 : $clog2(TIMEOUT_CYCLE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLE);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A kick always wins over saturation, so a fresh value clears stale on
   // the very next cycle even if the timer had already expired.
   always_comb begin
      cnt_d = cnt_q;
      if (kick) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= CNT_MAX;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stale = (cnt_q == CNT_MAX);

endmodule

// File: rtl/vehicle_data_receiver.sv
// Vehicle data receiver: accepts one CAN frame per 3 cycles on a valid/ready
// stream, decodes engine rpm / vehicle speed, and flags stale values.
// Latency: handshake edge -> DECODE -> COMMIT edge; outputs and one-cycle
// strobes (engine_rev_update, vehicle_speed_update, frame_error) appear after
// the COMMIT edge, two clocks after the handshake edge. tready is low while a
// frame is in flight, so the sender is back-pressured for two cycles.
// Ports: clk/rst_n (sync active-low), stm_recv_data_in_* stream input,
// engine_rev/vehicle_speed values, *_update strobes, *_stale flags,
// frame_error strobe. Optional build macro VEHICLE_RX_STATS_EN adds
// rx_frame_count (handshakes) and rx_error_count (frame_error pulses).
module vehicle_data_receiver
   import vehicle_can_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
   parameter logic [10:0] ID_ENGINE_REV = DEF_ID_ENGINE_REV,
   parameter logic [10:0] ID_CAR_SPEED  = DEF_ID_CAR_SPEED,
   parameter int unsigned TIMEOUT_CYCLE = CLK_FREQ_HZ / 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [63:0]                stm_recv_data_in_tdata,
   input  logic [10:0]                stm_recv_data_in_tid,
   input  logic [7:0]                 stm_recv_data_in_tkeep,
   input  logic                       stm_recv_data_in_tvalid,
   output logic                       stm_recv_data_in_tready,
   output logic [ENGINE_REV_W-1:0]    engine_rev,
   output logic [VEHICLE_SPEED_W-1:0] vehicle_speed,
   output logic                       engine_rev_update,
   output logic                       vehicle_speed_update,
   output logic                       engine_rev_stale,
   output logic                       vehicle_speed_stale,
   output logic                       frame_error
`ifdef VEHICLE_RX_STATS_EN
   ,
   output logic [15:0]                rx_frame_count,
   output logic [15:0]                rx_error_count
`endif
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   rx_state_t   state_q, state_d;
   logic        tready_q;

   logic [63:0] data_q;
   logic [10:0] id_q;
   logic [7:0]  keep_q;

   frame_kind_t kind_q, kind_d;
   logic        ok_q, ok_d;

   logic [ENGINE_REV_W-1:0]    eng_q, eng_d;
   logic [VEHICLE_SPEED_W-1:0] spd_q, spd_d;
   logic                       eng_upd_q, eng_upd_d;
   logic                       spd_upd_q, spd_upd_d;
   logic                       err_q, err_d;

   logic hs;
   logic commit;

   // Only the two low payload bytes and their keep bits carry information.
   logic unused_bits;
   assign unused_bits = ^{data_q[63:16], keep_q[7:2]};

   // tready is registered so it is low throughout reset and rises on the
   // first cycle after release; it is only ever high in IDLE.
   assign hs     = stm_recv_data_in_tvalid & tready_q;
   assign commit = (state_q == ST_COMMIT);

   // ---------------------------------------------------------------------
   // FSM: IDLE -> DECODE -> COMMIT -> IDLE, one frame per three cycles.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (hs) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // DECODE: classify by ID and check the payload. The engine ID is tested
   // first so a misconfiguration with equal IDs still decodes as engine.
   // ---------------------------------------------------------------------
   always_comb begin
      kind_d = FRM_OTHER;
      if (id_q == ID_ENGINE_REV) begin
         kind_d = FRM_ENGINE;
      end else if (id_q == ID_CAR_SPEED) begin
         kind_d = FRM_SPEED;
      end
   end

   always_comb begin
      ok_d = 1'b0;
      case (kind_d)
         FRM_ENGINE: ok_d = engine_frame_ok(keep_q[1:0], data_q[15:8]);
         FRM_SPEED:  ok_d = speed_frame_ok(keep_q[1:0], data_q[15:8]);
         default:    ok_d = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // COMMIT: write the matching value or raise an error. Frames with an
   // unknown ID fall through with neither strobe nor error.
   // ---------------------------------------------------------------------
   always_comb begin
      eng_upd_d = commit && (kind_q == FRM_ENGINE) && ok_q;
      spd_upd_d = commit && (kind_q == FRM_SPEED) && ok_q;
      err_d     = commit && (kind_q != FRM_OTHER) && !ok_q;

      eng_d = eng_q;
      spd_d = spd_q;
      if (eng_upd_d) begin
         eng_d = data_q[ENGINE_REV_W-1:0];     // {byte1[5:0], byte0}
      end
      if (spd_upd_d) begin
         spd_d = data_q[VEHICLE_SPEED_W-1:0];  // {byte1[0], byte0}
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tready_q  <= 1'b0;
         data_q    <= '0;
         id_q      <= '0;
         keep_q    <= '0;
         kind_q    <= FRM_OTHER;
         ok_q      <= 1'b0;
         eng_q     <= '0;
         spd_q     <= '0;
         eng_upd_q <= 1'b0;
         spd_upd_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tready_q <= (state_d == ST_IDLE);
         // The frame is captured once; tvalid/tdata changes afterwards are
         // ignored until the FSM is back in IDLE.
         if (hs) begin
            data_q <= stm_recv_data_in_tdata;
            id_q   <= stm_recv_data_in_tid;
            keep_q <= stm_recv_data_in_tkeep;
         end
         if (state_q == ST_DECODE) begin
            kind_q <= kind_d;
            ok_q   <= ok_d;
         end
         eng_q     <= eng_d;
         spd_q     <= spd_d;
         eng_upd_q <= eng_upd_d;
         spd_upd_q <= spd_upd_d;
         err_q     <= err_d;
      end
   end

   assign stm_recv_data_in_tready = tready_q;
   assign engine_rev              = eng_q;
   assign vehicle_speed           = spd_q;
   assign engine_rev_update       = eng_upd_q;
   assign vehicle_speed_update    = spd_upd_q;
   assign frame_error             = err_q;

   // ---------------------------------------------------------------------
   // Staleness: timers are kicked at the COMMIT edge, together with the
   // value write, so stale drops in the same cycle the strobe is visible
   // and rises TIMEOUT_CYCLE cycles after the last strobe.
   // ---------------------------------------------------------------------
   rx_timeout_timer #(
      .TIMEOUT_CYCLE (TIMEOUT_CYCLE)
   ) u_eng_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .kick  (eng_upd_d),
      .stale (engine_rev_stale)
   );

   rx_timeout_timer #(
      .TIMEOUT_CYCLE (TIMEOUT_CYCLE)
   ) u_spd_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .kick  (spd_upd_d),
      .stale (vehicle_speed_stale)
   );

`ifdef VEHICLE_RX_STATS_EN
   // ---------------------------------------------------------------------
   // Saturating receive statistics.
   // ---------------------------------------------------------------------
   logic [15:0] frm_cnt_q, frm_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      if (hs && (frm_cnt_q != 16'hFFFF)) begin
         frm_cnt_d = frm_cnt_q + 16'd1;
      end
      if (err_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rx_frame_count = frm_cnt_q;
   assign rx_error_count = err_cnt_q;
`endif

endmodule
